// File: rtl/heapsort_param.sv
`default_nettype none
// ============================================================================
// Module   : heapsort_param
// Captures a block of 2**ADDR_W samples, heapsorts it in place in a dual-port
// RAM and streams the sorted block out at the input sample rate.
// Revision : 1.0 - initial release
// ============================================================================
module heapsort_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fs,
  input  logic              en_rec_in,
  input  logic              order,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy,
  output logic              overrun
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] FIRST_PARENT = ADDR_W'(DEPTH/2 - 1);
  localparam logic [ADDR_W:0]   FULL_SIZE    = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_LOAD, S_BUILD_RD, S_EXT_RD, S_PAR, S_CH_RD, S_CMP, S_OUT
  } state_t;

  state_t              state;
  logic                fs_d, ord, building, pend, pend_last;
  logic [ADDR_W-1:0]   wp, idx, bidx;
  logic [ADDR_W:0]     size, size_m1;
  logic [DATA_W-1:0]   pval;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   qa, qb, wd_a, wd_b;
  logic [ADDR_W-1:0]   addr_a, addr_b;
  logic                we_a, we_b;

  logic                ev, has_r, r_wins, swap, child_leaf;
  logic [ADDR_W+1:0]   l, r, size_x;
  logic [DATA_W-1:0]   best;
  logic [ADDR_W-1:0]   child, last_addr;

  // True when a should sit above b in the heap (max-heap ascending, min-heap descending)
  function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                  input logic desc);
    logic gt, lt;
    if (SIGNED != 0) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return desc ? lt : gt;
  endfunction

  assign ev         = fs & ~fs_d;
  assign l          = {1'b0, idx, 1'b1};
  assign r          = l + (ADDR_W+2)'(1);
  assign size_x     = {1'b0, size};
  assign size_m1    = size - 1'b1;
  assign last_addr  = size_m1[ADDR_W-1:0];
  assign has_r      = r < size_x;
  assign r_wins     = has_r && better(qb, qa, ord);
  assign best       = r_wins ? qb : qa;
  assign child      = r_wins ? r[ADDR_W-1:0] : l[ADDR_W-1:0];
  assign swap       = better(best, pval, ord);
  assign child_leaf = {1'b0, child, 1'b1} >= size_x;

  // The sifted value rides in pval and is only written once it settles.
  always_comb begin
    we_a   = 1'b0;
    we_b   = 1'b0;
    addr_a = idx;
    addr_b = idx;
    wd_a   = pval;
    wd_b   = pval;
    case (state)
      S_LOAD: begin
        addr_a = wp;
        wd_a   = data_in;
        we_a   = ev & en_rec_in;
      end
      S_EXT_RD: begin
        addr_a = '0;
        addr_b = last_addr;
      end
      S_PAR: begin
        if (!building) begin
          we_a   = 1'b1;
          addr_a = last_addr;
          wd_a   = qa;
          if (size == (ADDR_W+1)'(2)) begin
            we_b   = 1'b1;
            addr_b = '0;
            wd_b   = qb;
          end
        end
      end
      S_CH_RD: begin
        addr_a = l[ADDR_W-1:0];
        addr_b = r[ADDR_W-1:0];
      end
      S_CMP: begin
        we_a = 1'b1;
        wd_a = swap ? best : pval;
        if (swap && child_leaf) begin
          we_b   = 1'b1;
          addr_b = child;
        end
      end
      S_OUT:   addr_a = wp;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wd_a;
    if (we_b) mem[addr_b] <= wd_b;
    qa <= mem[addr_a];
    qb <= mem[addr_b];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LOAD;
      wp        <= '0;
      idx       <= '0;
      bidx      <= '0;
      size      <= '0;
      pval      <= '0;
      fs_d      <= 1'b0;
      ord       <= 1'b0;
      building  <= 1'b0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      data_out  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      fs_d      <= fs;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      if (ev && en_rec_in && state != S_LOAD) overrun <= 1'b1;
      case (state)
        S_LOAD: begin
          if (ev && en_rec_in) begin
            wp <= wp + 1'b1;
            if (&wp) begin
              state    <= S_BUILD_RD;
              busy     <= 1'b1;
              ord      <= order;
              building <= 1'b1;
              size     <= FULL_SIZE;
              idx      <= FIRST_PARENT;
              bidx     <= FIRST_PARENT;
            end
          end
        end
        S_BUILD_RD: state <= S_PAR;
        S_EXT_RD:   state <= S_PAR;
        S_PAR: begin
          if (building) begin
            pval  <= qa;
            state <= S_CH_RD;
          end else begin
            pval  <= qb;
            size  <= size_m1;
            state <= (size == (ADDR_W+1)'(2)) ? S_OUT : S_CH_RD;
          end
        end
        S_CH_RD: state <= S_CMP;
        S_CMP: begin
          if (swap && !child_leaf) begin
            idx   <= child;
            state <= S_CH_RD;
          end else if (building && bidx != '0) begin
            bidx  <= bidx - 1'b1;
            idx   <= bidx - 1'b1;
            state <= S_BUILD_RD;
          end else begin
            building <= 1'b0;
            idx      <= '0;
            state    <= S_EXT_RD;
          end
        end
        S_OUT: begin
          pend <= ev;
          if (ev) begin
            pend_last <= &wp;
            wp        <= wp + 1'b1;
          end
          if (pend) begin
            data_out  <= qa;
            out_valid <= 1'b1;
            out_last  <= pend_last;
            if (pend_last) begin
              state <= S_LOAD;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/heapsort_param.md
Name: heapsort_param

Overview:
Parametrised successor to the fixed 16-bit heapsort block. Captures a block of 2**ADDR_W samples on rising edges of the sample strobe fs, sorts them in place in an internal dual-port RAM using heapsort, and streams the sorted block out.
Adds configurable data width and depth, signed/unsigned compare, a runtime ascending/descending mode, and output framing and overrun flags.

Parameters:
DATA_W, 16, sample width in bits
ADDR_W, 10, log2 of block depth; DEPTH = 2**ADDR_W, minimum ADDR_W = 2
SIGNED, 0, 1 = two's-complement compare, 0 = unsigned compare

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous active-high reset
fs  in  1  sample strobe, level signal synchronous to clk; each 0->1 transition (detected against a registered copy) is one sample event
en_rec_in  in  1  enables capture of samples in LOAD
order  in  1  0 = ascending, 1 = descending; latched on entry to SORT
data_in  in  DATA_W  sample, taken on the clk edge where the fs rise is detected
data_out  out  DATA_W  sorted sample
out_valid  out  1  one-clk pulse per emitted sample
out_last  out  1  high with out_valid on the final element of a block
busy  out  1  high in SORT and OUT
overrun  out  1  sticky; set when a sample event with en_rec_in=1 occurs while busy; cleared only by rst

Behaviour:
- Reset (rst=1 at a clk edge): state=LOAD, write pointer=0, fs history register=0, order latch=0, data_out=0, out_valid=0, out_last=0, busy=0, overrun=0. RAM contents are don't-care.
- Reset mid-operation (SORT or OUT) aborts the block immediately. No further out_valid pulses occur.
- Sample event: fs=1 and fs_d=0 at a clk edge. An fs rise that is already present during reset counts as an event on the first post-reset edge.
- LOAD state:
  - On an event with en_rec_in=1, write data_in to RAM[wp] and increment wp.
  - When the write fills address DEPTH-1, go to SORT on the next clk. wp wraps to 0.
  - Events with en_rec_in=0 are ignored; wp holds.
- SORT state:
  - busy=1. Latch order on entry.
  - Build phase: sift-down from index DEPTH/2-1 down to 0 on a 0-based heap (children at 2i+1 and 2i+2).
  - Extract phase: swap root with the last heap element, shrink the heap, sift-down, repeat until heap size is 1.
  - Compare rule:
    - Ascending builds a max-heap; descending builds a min-heap.
    - SIGNED selects the compare type.
    - Ties do not swap; stability is not required.
  - RAM read latency is 1 clk. Port A and port B may both read or both write in the same clk; writes to the same address in the same clk are never issued.
  - Sort completes in at most 4*DEPTH*(ADDR_W+1) clks, then goes to OUT.
- OUT state:
  - Emit RAM[0..DEPTH-1] in address order, one element per sample event regardless of en_rec_in, so output runs at the input sample rate.
  - data_out updates and out_valid pulses for one clk, at most 2 clks after the event edge (fixed latency).
  - out_last accompanies address DEPTH-1.
  - data_out holds its last value between pulses.
- After the last element, return to LOAD with wp=0 and busy=0.
- Events during SORT and OUT are never written to RAM. If en_rec_in=1, they set overrun.
- Event on the same clk as the LOAD->SORT transition: it belongs to SORT, so it is dropped and flagged.
- Ordering guarantee: the output sequence is non-decreasing (ascending) or non-increasing (descending) and is a permutation of the loaded block.

Test Plan:
1. ADDR_W=3, SIGNED=0, order=0, load 5,3,7,1,0,6,2,4 (one per fs rise) -> out 0,1,2,3,4,5,6,7; out_last only with 7; busy falls after.
2. ADDR_W=3, SIGNED=1, DATA_W=16, order=1, load 0xFFFF,0x0002,0x8000,0x7FFF,0,1,0xFFFE,3 -> out 0x7FFF,3,2,1,0,0xFFFF,0xFFFE,0x8000.
3. ADDR_W=2, all samples 0x00AA -> four out_valid pulses of 0x00AA; sort finishes within 4*4*3=48 clks.
4. ADDR_W=3: toggle en_rec_in low for 3 events during LOAD -> those samples are absent; the block completes after 8 enabled events; then an enabled event during SORT -> overrun=1, stays 1 through the next block.
5. Assert rst for 1 clk mid-SORT -> all outputs 0 next clk. Reload 8 new values -> correct sorted output with no stale data.
6. ADDR_W=10 default, 1024 random 16-bit values, two back-to-back blocks with alternating order -> each output block is monotone per order and its multiset matches the model.
